// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the data-memory responder:
//   - state_e    : responder FSM states (CLEAR walks zeros, READY serves)
//   - *_DEF      : default widths matching the processor datapath
//   - ZERO_WORD  : all-zero constant, cast down to DATA_WIDTH by users
// -----------------------------------------------------------------------------
package data_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DATA_WIDTH_DEF = 20;
  localparam int ADDR_WIDTH_DEF = 20;
  localparam int DEPTH_LOG2_DEF = 8;

  // Wide enough for any sensible DATA_WIDTH; users cast to their own width.
  localparam logic [63:0] ZERO_WORD = '0;

endpackage

// File: rtl/data_memory_array.sv
// -----------------------------------------------------------------------------
// data_memory_array
// 2**DEPTH_LOG2 x DATA_WIDTH storage, one synchronous write port and one
// asynchronous read port (the processor needs same-cycle read data).
// Ports:
//   clk      in   clock, writes on rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write word index
//   wr_data  in   write data
//   rd_addr  in   read word index
//   rd_data  out  read data, combinational from rd_addr
// -----------------------------------------------------------------------------
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Responder side of the processor data-memory interface. After reset the
// array is walked to zero (CLEAR), then READY serves zero-latency reads and
// arbitrates one array write per cycle: Load > Pending > Processor store.
// A one-entry pending buffer absorbs a processor store that collides with a
// loader write; reads bypass from it while it is occupied.
// Ports:
//   Clock, Reset     single clock, synchronous active-high reset
//   MemAddress       processor word address
//   MemWriteData     processor store data
//   MemWriteEnable   processor store request
//   MemReadData      combinational read data for MemAddress
//   LoadEnable/LoadAddress/LoadData   side loader write port
//   Busy             clearing, or pending buffer occupied (advisory)
//   RangeError       sticky: some access used an address beyond the array
//   WriteDropped     sticky: a processor store was lost to arbitration
// -----------------------------------------------------------------------------
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DEPTH_LOG2     = DEPTH_LOG2_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] MemAddress,
  input  logic [DATA_WIDTH-1:0] MemWriteData,
  input  logic                  MemWriteEnable,
  output logic [DATA_WIDTH-1:0] MemReadData,
  input  logic                  LoadEnable,
  input  logic [ADDR_WIDTH-1:0] LoadAddress,
  input  logic [DATA_WIDTH-1:0] LoadData,
  output logic                  Busy,
  output logic                  RangeError,
  output logic                  WriteDropped
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;
  localparam logic [DATA_WIDTH-1:0] ZERO     = DATA_WIDTH'(ZERO_WORD);

  // Full-width compare: every bit above the index must be zero.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> DEPTH_LOG2) == '0;
  endfunction

  state_e                  state_q,      state_d;
  logic [DEPTH_LOG2-1:0]   clr_cnt_q,    clr_cnt_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [DEPTH_LOG2-1:0]   pend_addr_q,  pend_addr_d;
  logic [DATA_WIDTH-1:0]   pend_data_q,  pend_data_d;
  logic                    range_err_q,  range_err_d;
  logic                    wr_drop_q,    wr_drop_d;

  logic                    arr_we;
  logic [DEPTH_LOG2-1:0]   arr_waddr;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  logic                    mem_ok, ld_ok, ld_go, st_go;
  logic [DEPTH_LOG2-1:0]   mem_idx, ld_idx;

  assign mem_ok  = in_range(MemAddress);
  assign ld_ok   = in_range(LoadAddress);
  assign mem_idx = MemAddress[DEPTH_LOG2-1:0];
  assign ld_idx  = LoadAddress[DEPTH_LOG2-1:0];
  // Out-of-range requests never reach the array or the pending buffer.
  assign ld_go   = LoadEnable & ld_ok;
  assign st_go   = MemWriteEnable & mem_ok;

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (Clock),
    .wr_en   (arr_we),
    .wr_addr (arr_waddr),
    .wr_data (arr_wdata),
    .rd_addr (mem_idx),
    .rd_data (arr_rdata)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      range_err_q  <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      range_err_q  <= range_err_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  // Next-state logic: CLEAR writes the last word at LAST_IDX, then READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_IDX) begin
        state_d = READY;
      end
    end
  end

  // Output / datapath logic: read mux, write arbitration, pending, flags.
  always_comb begin
    arr_we       = 1'b0;
    arr_waddr    = clr_cnt_q;
    arr_wdata    = ZERO;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    range_err_d  = range_err_q;
    wr_drop_d    = wr_drop_q;
    MemReadData  = ZERO;

    if (state_q == CLEAR) begin
      // Requests during the clear walk are silently ignored.
      arr_we = 1'b1;
    end else begin
      range_err_d = range_err_q | ~mem_ok | (LoadEnable & ~ld_ok);

      if (!mem_ok) begin
        MemReadData = ZERO;
      end else if (pend_valid_q && (pend_addr_q == mem_idx)) begin
        MemReadData = pend_data_q;
      end else begin
        MemReadData = arr_rdata;
      end

      if (ld_go) begin
        arr_we    = 1'b1;
        arr_waddr = ld_idx;
        arr_wdata = LoadData;
        if (st_go) begin
          if (pending_full(pend_valid_q)) begin
            wr_drop_d = 1'b1;
          end else begin
            // Parked store commits after the load, so it wins on a same
            // address collision.
            pend_valid_d = 1'b1;
            pend_addr_d  = mem_idx;
            pend_data_d  = MemWriteData;
          end
        end
      end else if (pend_valid_q) begin
        arr_we    = 1'b1;
        arr_waddr = pend_addr_q;
        arr_wdata = pend_data_q;
        if (st_go) begin
          pend_addr_d = mem_idx;
          pend_data_d = MemWriteData;
        end else begin
          pend_valid_d = 1'b0;
        end
      end else if (st_go) begin
        arr_we    = 1'b1;
        arr_waddr = mem_idx;
        arr_wdata = MemWriteData;
      end
    end
  end

  function automatic logic pending_full(input logic v);
    return v;
  endfunction

  assign Busy         = (state_q == CLEAR) | pend_valid_q;
  assign RangeError   = range_err_q;
  assign WriteDropped = wr_drop_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// Directed bench for data_memory_responder. Inputs change on the falling
// edge; outputs are sampled a few ns later, before the next rising edge.
// Expected values go into a scoreboard queue and are popped at sampling.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int DW = 20;
  localparam int AW = 20;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [AW-1:0] MemAddress = 20'd5;
  logic [DW-1:0] MemWriteData = '0;
  logic          MemWriteEnable = 1'b0;
  logic [DW-1:0] MemReadData;
  logic          LoadEnable = 1'b0;
  logic [AW-1:0] LoadAddress = '0;
  logic [DW-1:0] LoadData = '0;
  logic          Busy;
  logic          RangeError;
  logic          WriteDropped;

  always #5 Clock = ~Clock;

  data_memory_responder #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .DEPTH_LOG2     (8),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .MemAddress     (MemAddress),
    .MemWriteData   (MemWriteData),
    .MemWriteEnable (MemWriteEnable),
    .MemReadData    (MemReadData),
    .LoadEnable     (LoadEnable),
    .LoadAddress    (LoadAddress),
    .LoadData       (LoadData),
    .Busy           (Busy),
    .RangeError     (RangeError),
    .WriteDropped   (WriteDropped)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string tag, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_obs(input logic [DW-1:0] obs);
    exp_t e;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
    $display("check %-20s observed=%h expected=%h", e.tag, obs, e.val);
  endtask

  // Combinational read of address a (write enables must be low).
  task automatic read_chk(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] v);
    MemAddress = a;
    expect_val(tag, v);
    #1;
    check_obs(MemReadData);
  endtask

  task automatic idle();
    MemWriteEnable = 1'b0;
    LoadEnable     = 1'b0;
  endtask

  // Called just after Reset is released on a falling edge. Counts Busy cycles,
  // watches read data stay zero, and pokes both write ports late in the walk
  // to confirm they are ignored.
  task automatic run_clear(input string tag);
    int busy_n = 0;
    bit nz     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!Busy) break;
      busy_n++;
      if (MemReadData !== '0) nz = 1'b1;
      @(negedge Clock);
      if (busy_n == 250) begin
        LoadEnable = 1'b1; LoadAddress = 20'd4; LoadData = 20'h12345;
        MemWriteEnable = 1'b1; MemAddress = 20'd6; MemWriteData = 20'h54321;
      end else begin
        idle();
        MemAddress = 20'd5;
      end
    end
    expect_val({tag, "_busy_cycles"}, 20'd256);
    check_obs(DW'(busy_n));
    expect_val({tag, "_read_zero"}, 20'd0);
    check_obs(DW'(nz));
    @(negedge Clock);
    read_chk({tag, "_rd5"}, 20'd5, 20'd0);
    read_chk({tag, "_ld_ignored"}, 20'd4, 20'd0);
    read_chk({tag, "_st_ignored"}, 20'd6, 20'd0);
    @(negedge Clock);
    expect_val({tag, "_range_err"}, 20'd0);
    #1 check_obs(DW'(RangeError));
    expect_val({tag, "_wr_dropped"}, 20'd0);
    check_obs(DW'(WriteDropped));
    MemAddress = 20'd5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge Clock);
    #1;
    expect_val("rst_busy", 20'd1);      check_obs(DW'(Busy));
    expect_val("rst_range_err", 20'd0); check_obs(DW'(RangeError));
    expect_val("rst_wr_dropped", 20'd0); check_obs(DW'(WriteDropped));
    expect_val("rst_read", 20'd0);      check_obs(MemReadData);
    @(negedge Clock);
    Reset = 1'b0;
    run_clear("clr1");

    // Store to 3: old value in the same cycle, new value next cycle
    @(negedge Clock);
    MemAddress = 20'd3; MemWriteData = 20'h0ABCD; MemWriteEnable = 1'b1;
    expect_val("st3_same_cycle", 20'd0);
    #1 check_obs(MemReadData);
    @(negedge Clock);
    idle();
    read_chk("st3_next", 20'd3, 20'h0ABCD);
    expect_val("st3_busy", 20'd0);
    check_obs(DW'(Busy));

    // Load + store to 7 in one cycle: store parks in pending, wins afterwards
    @(negedge Clock);
    LoadEnable = 1'b1; LoadAddress = 20'd7; LoadData = 20'h11111;
    MemWriteEnable = 1'b1; MemAddress = 20'd7; MemWriteData = 20'h22222;
    @(negedge Clock);
    idle();
    read_chk("a7_bypass", 20'd7, 20'h22222);
    expect_val("a7_busy_pend", 20'd1);
    check_obs(DW'(Busy));
    @(negedge Clock);
    read_chk("a7_committed", 20'd7, 20'h22222);
    expect_val("a7_busy_clear", 20'd0);
    check_obs(DW'(Busy));

    // Fill pending, then load + store with pending full: store to 9 dropped
    @(negedge Clock);
    LoadEnable = 1'b1; LoadAddress = 20'd20; LoadData = 20'h44444;
    MemWriteEnable = 1'b1; MemAddress = 20'd21; MemWriteData = 20'h55555;
    @(negedge Clock);
    LoadAddress = 20'd22; LoadData = 20'h66666;
    MemAddress = 20'd9; MemWriteData = 20'h33333;
    @(negedge Clock);
    idle();
    #1;
    expect_val("drop_flag", 20'd1);      check_obs(DW'(WriteDropped));
    expect_val("drop_busy_held", 20'd1); check_obs(DW'(Busy));
    read_chk("drop_a9", 20'd9, 20'd0);
    read_chk("drop_a21_bypass", 20'd21, 20'h55555);
    @(negedge Clock);
    read_chk("drop_a21", 20'd21, 20'h55555);
    read_chk("drop_a22", 20'd22, 20'h66666);
    read_chk("drop_a20", 20'd20, 20'h44444);
    repeat (3) @(negedge Clock);
    read_chk("drop_a9_later", 20'd9, 20'd0);
    expect_val("drop_sticky", 20'd1);    check_obs(DW'(WriteDropped));
    expect_val("pre_range_err", 20'd0);  check_obs(DW'(RangeError));

    // Out-of-range store and read
    @(negedge Clock);
    MemAddress = 20'h00100; MemWriteData = 20'h77777; MemWriteEnable = 1'b1;
    expect_val("oor_store_read", 20'd0);
    #1 check_obs(MemReadData);
    @(negedge Clock);
    idle();
    read_chk("oor_read_ffff", 20'hFFFFF, 20'd0);
    expect_val("oor_range_err", 20'd1);
    check_obs(DW'(RangeError));
    @(negedge Clock);
    read_chk("oor_a0_intact", 20'd0, 20'd0);
    expect_val("oor_sticky", 20'd1);
    check_obs(DW'(RangeError));

    // Reset clears the sticky flags
    @(negedge Clock);
    Reset = 1'b1; MemAddress = 20'd5;
    @(negedge Clock);
    #1;
    expect_val("rst2_range_err", 20'd0);  check_obs(DW'(RangeError));
    expect_val("rst2_wr_dropped", 20'd0); check_obs(DW'(WriteDropped));
    expect_val("rst2_busy", 20'd1);       check_obs(DW'(Busy));

    // Reset in the middle of the clear walk (counter = 100)
    @(negedge Clock);
    Reset = 1'b0;
    repeat (100) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    run_clear("clr2");
    @(negedge Clock);
    read_chk("clr2_a3_zeroed", 20'd3, 20'd0);
    read_chk("clr2_a7_zeroed", 20'd7, 20'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the processor's data-memory interface. It receives the MEM-stage address, write data and write enable, and returns read data that the MEM/WB register samples as memory read data.
- Holds a word-addressed data array that is zero-cleared after reset.
- Has a side loader port so a bench or boot block can preload data.
- One array write port, arbitrated through a one-entry pending-write buffer.

Parameters:
- DATA_WIDTH, 20, word width; matches the processor datapath.
- ADDR_WIDTH, 20, width of the incoming address bus.
- DEPTH_LOG2, 8, array holds 2**DEPTH_LOG2 words (256).
- CLEAR_ON_RESET, 1, 1 = walk-zero the array after reset; 0 = go straight to READY with contents undefined.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- MemAddress  in  ADDR_WIDTH  word address from the MEM stage (12-bit immediates arrive zero-extended).
- MemWriteData  in  DATA_WIDTH  store data.
- MemWriteEnable  in  1  store request this cycle.
- MemReadData  out  DATA_WIDTH  read data for MemAddress, combinational.
- LoadEnable  in  1  loader write request.
- LoadAddress  in  ADDR_WIDTH  loader word address.
- LoadData  in  DATA_WIDTH  loader data.
- Busy  out  1  clearing in progress or pending buffer occupied.
- RangeError  out  1  sticky: an access hit address >= 2**DEPTH_LOG2.
- WriteDropped  out  1  sticky: a processor store was lost to arbitration.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high; ports are named Clock and Reset.
  - Reset, including mid-CLEAR, sets state = CLEAR (or READY if CLEAR_ON_RESET=0), clear counter = 0, pending valid = 0, RangeError = 0, WriteDropped = 0.
  - Array contents are not reset directly.
- FSM states CLEAR and READY:
  - CLEAR writes 0 to word[counter] each cycle and increments the counter. At counter = 2**DEPTH_LOG2-1 it writes the last word, then moves to READY next cycle.
  - Clear of 256 words takes exactly 256 cycles after Reset deasserts.
  - During CLEAR: Busy = 1, MemReadData = 0, processor and loader writes are ignored and not flagged.
  - No transition leaves READY except Reset.
- Read path (READY):
  - MemReadData is a combinational function of MemAddress and current state, with zero latency. This is required because MEM/WB samples it at the end of the MEM cycle.
  - Priority: out of range -> 0 (and RangeError sets next edge); pending valid and address match -> pending data; otherwise word[addr].
  - A write in the same cycle becomes visible to reads from the next cycle.
- Write arbitration (READY): one array write per cycle, priority Load > Pending > Processor.
  - Load only: array write.
  - Processor only, pending empty: array write.
  - Load + processor: load writes the array; the processor store goes to pending.
  - Pending valid, no load: pending commits. A processor store in the same cycle refills pending; otherwise pending empties.
  - Pending valid + load + processor store: pending holds, the processor store is discarded and WriteDropped sets.
  - Same-address load + processor store in one cycle: the processor value ends up final once pending commits.
- Range rules:
  - Out-of-range writes from either port are ignored and set RangeError.
  - Out-of-range reads also set RangeError.
  - Address comparison uses the full ADDR_WIDTH; the high bits must be zero.
- Busy = (state == CLEAR) | pending valid. It is advisory only; the processor does not stall on it.

Decomposition:
- Shared package data_memory_pkg holds:
  - state typedef {CLEAR, READY};
  - DATA_WIDTH and DEPTH_LOG2 defaults;
  - a zero-word constant.
- One sub-module, data_memory_array: 2**DEPTH_LOG2 x DATA_WIDTH, one synchronous write port, one asynchronous read port.
- The FSM, arbitration, pending buffer and flags live in the top level.

Test Plan:
- Reset released; read addr 5 during the 256-cycle CLEAR and after -> Busy = 1 for exactly 256 cycles, then 0; MemReadData = 0 throughout.
- READY; store 0x0ABCD to addr 3, next cycle read addr 3 -> 0x0ABCD; same-cycle read before the edge returns the old value 0.
- LoadEnable (addr 7, 0x11111) + store (addr 7, 0x22222) in the same cycle -> Busy = 1 for 1 cycle; read addr 7 next cycle = 0x22222 via bypass; after commit, array word 7 = 0x22222.
- Pending valid + load + store (addr 9, 0x33333) in the same cycle -> WriteDropped = 1 and stays 1; addr 9 unchanged (0).
- Store to addr 0x00100 (DEPTH 256) and read addr 0xFFFFF -> RangeError = 1, MemReadData = 0, no array change; Reset clears RangeError.
- Reset asserted at clear counter = 100 -> counter restarts at 0; Busy stays high for a full 256 cycles after release.
